// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } muldiv_state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Strobes broadcast to every bitslice in the array
  typedef struct packed {
    logic load_divl;
    logic load_divh;
    logic load_acc;
    logic load_quot;
    logic load_rem;
    logic divh_p;
    logic divl_p;
    logic acc_cin;
    logic inv_op1;
    logic inv_op2;
    logic inv_rem;
    logic inv_result;
  } slice_ctrl_t;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// muldiv_iter_cnt: loadable down-counter with a zero flag; holds at zero.
module muldiv_iter_cnt
  import muldiv_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: control FSM for a WIDTH-slice iterative multiply/divide
// datapath. Optional macro MULDIV_SIGNED_EN adds signed magnitude conversion
// in LOAD and sign fixup in FIXUP; without it Signed is ignored.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Op,
  input  logic Signed,
  input  logic Op1Sign,
  input  logic Op2Sign,
  input  logic MplrBit,
  input  logic ACC_Cout,
  input  logic DivisorZero,
  output logic Busy,
  output logic Done,
  output logic DivErr,
  output logic LOAD_DIVL,
  output logic LOAD_DIVH,
  output logic LOAD_ACC,
  output logic LOAD_QUOT,
  output logic LOAD_REM,
  output logic DIVH_P,
  output logic DIVL_P,
  output logic ACC_Cin,
  output logic INV_OP1,
  output logic INV_OP2,
  output logic INV_REM,
  output logic INV_RESULT
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LOAD  = LOAD;
  localparam logic [2:0] ST_ITER  = ITER;
  localparam logic [2:0] ST_FIXUP = FIXUP;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]  state_q, state_d;
  logic        op_q, op_d;
  logic        div_err_q, div_err_d;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        busy, done;
  slice_ctrl_t ctrl;

`ifdef MULDIV_SIGNED_EN
  logic signed_q, signed_d;
`else
  logic sign_unused;
  assign sign_unused = ^{Signed, Op1Sign, Op2Sign};
`endif

  muldiv_iter_cnt #(
    .CNT_W(CNT_W)
  ) u_iter_cnt (
    .clk     (Clock),
    .rst     (Reset),
    .load    (cnt_load),
    .load_val(CNT_W'(WIDTH - 1)),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // Sequencing: one operation in flight, Start only honoured in IDLE
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    div_err_d = div_err_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
`ifdef MULDIV_SIGNED_EN
    signed_d  = signed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_LOAD;
          op_d    = Op;
`ifdef MULDIV_SIGNED_EN
          signed_d = Signed;
`endif
        end
      end
      ST_LOAD: begin
        if ((op_q == OP_DIV) && DivisorZero) begin
          state_d   = ST_DONE;
          div_err_d = 1'b1;
        end else begin
          state_d   = ST_ITER;
          div_err_d = 1'b0;
          cnt_load  = 1'b1;
        end
      end
      ST_ITER: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Slice strobes decoded from state; divide steps use this cycle's carry
  always_comb begin
    ctrl = '0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_LOAD: begin
        busy = 1'b1;
        if ((op_q == OP_DIV) && DivisorZero) begin
          // Quotient forced to all ones on divide-by-zero
          ctrl.load_quot  = 1'b1;
          ctrl.inv_result = 1'b1;
        end else begin
          ctrl.load_divl = 1'b1;
          ctrl.load_divh = 1'b1;
`ifdef MULDIV_SIGNED_EN
          if (signed_q) begin
            ctrl.inv_op1 = Op1Sign;
            ctrl.inv_op2 = Op2Sign;
          end
`endif
        end
      end
      ST_ITER: begin
        busy = 1'b1;
        if (op_q == OP_MUL) begin
          ctrl.load_acc = MplrBit;
          ctrl.divl_p   = 1'b1;
          ctrl.divh_p   = 1'b1;
        end else begin
          // Restoring step: trial subtract, commit only on no-borrow
          ctrl.divh_p     = 1'b1;
          ctrl.inv_op2    = 1'b1;
          ctrl.acc_cin    = 1'b1;
          ctrl.load_acc   = ACC_Cout;
          ctrl.load_quot  = 1'b1;
          ctrl.inv_result = ~ACC_Cout;
        end
      end
      ST_FIXUP: begin
        busy          = 1'b1;
        ctrl.load_rem = (op_q == OP_DIV);
`ifdef MULDIV_SIGNED_EN
        if (signed_q) begin
          ctrl.inv_result = Op1Sign ^ Op2Sign;
          ctrl.inv_rem    = Op1Sign;
          ctrl.acc_cin    = 1'b1;
        end
`endif
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Control registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      div_err_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      signed_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      div_err_q <= div_err_d;
`ifdef MULDIV_SIGNED_EN
      signed_q  <= signed_d;
`endif
    end
  end

  assign Busy       = busy;
  assign Done       = done;
  assign DivErr     = div_err_q;
  assign LOAD_DIVL  = ctrl.load_divl;
  assign LOAD_DIVH  = ctrl.load_divh;
  assign LOAD_ACC   = ctrl.load_acc;
  assign LOAD_QUOT  = ctrl.load_quot;
  assign LOAD_REM   = ctrl.load_rem;
  assign DIVH_P     = ctrl.divh_p;
  assign DIVL_P     = ctrl.divl_p;
  assign ACC_Cin    = ctrl.acc_cin;
  assign INV_OP1    = ctrl.inv_op1;
  assign INV_OP2    = ctrl.inv_op2;
  assign INV_REM    = ctrl.inv_rem;
  assign INV_RESULT = ctrl.inv_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized bench with a slice-array data model and a
// cycle-indexed schedule model for muldiv_sequencer.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  localparam int W = 8;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int B_BUSY = 13, B_DONE = 12, B_LDIVL = 11, B_LDIVH = 10;
  localparam int B_LACC = 9, B_LQUOT = 8, B_LREM = 7, B_DIVHP = 6, B_DIVLP = 5;
  localparam int B_CIN = 4, B_IOP1 = 3, B_IOP2 = 2, B_IREM = 1, B_IRES = 0;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic Op = 1'b0;
  logic Signed = 1'b0;
  logic [W-1:0] tb_a = '0;
  logic [W-1:0] tb_b = '0;
  logic Op1Sign, Op2Sign, MplrBit, ACC_Cout, DivisorZero;
  logic Busy, Done, DivErr, LOAD_DIVL, LOAD_DIVH, LOAD_ACC, LOAD_QUOT, LOAD_REM;
  logic DIVH_P, DIVL_P, ACC_Cin, INV_OP1, INV_OP2, INV_REM, INV_RESULT;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .Signed(Signed),
    .Op1Sign(Op1Sign), .Op2Sign(Op2Sign), .MplrBit(MplrBit), .ACC_Cout(ACC_Cout),
    .DivisorZero(DivisorZero), .Busy(Busy), .Done(Done), .DivErr(DivErr),
    .LOAD_DIVL(LOAD_DIVL), .LOAD_DIVH(LOAD_DIVH), .LOAD_ACC(LOAD_ACC),
    .LOAD_QUOT(LOAD_QUOT), .LOAD_REM(LOAD_REM), .DIVH_P(DIVH_P), .DIVL_P(DIVL_P),
    .ACC_Cin(ACC_Cin), .INV_OP1(INV_OP1), .INV_OP2(INV_OP2), .INV_REM(INV_REM),
    .INV_RESULT(INV_RESULT)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- slice array data model ----------------
  logic [W-1:0] m_divh = '0, m_divl = '0, m_opd = '0, m_quot = '0, m_rem = '0;
  logic [13:0]  cap_v = '0;
  logic [13:0]  dut_vec;
  logic [W:0]   shifted, trial, mul_sum;
  logic [2*W-1:0] prod_neg;

  assign dut_vec = {Busy, Done, LOAD_DIVL, LOAD_DIVH, LOAD_ACC, LOAD_QUOT, LOAD_REM,
                    DIVH_P, DIVL_P, ACC_Cin, INV_OP1, INV_OP2, INV_REM, INV_RESULT};
  assign Op1Sign     = tb_a[W-1];
  assign Op2Sign     = tb_b[W-1];
  assign DivisorZero = (tb_b == '0);
  assign MplrBit     = m_divl[0];
  assign shifted     = {m_divh, m_divl[W-1]};
  assign trial       = shifted - {1'b0, m_opd};
  assign ACC_Cout    = (shifted >= {1'b0, m_opd});
  assign mul_sum     = {1'b0, m_divh} + (cap_v[B_LACC] ? {1'b0, m_opd} : {(W+1){1'b0}});
  assign prod_neg    = -{m_divh, m_divl};

  // schedule tracker: cycles since the accepted Start
  int   k = 0;
  logic e_op = 1'b0, e_sgn = 1'b0, e_err = 1'b0, armed = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      k <= 0; e_err <= 1'b0; armed <= 1'b1;
    end else if (k == 0) begin
      if (Start) begin k <= 1; e_op <= Op; e_sgn <= Signed; end
    end else if (k == 1 && e_op && DivisorZero) begin
      k <= W + 3; e_err <= 1'b1;
    end else begin
      if (k == 1) e_err <= 1'b0;
      k <= (k == W + 3) ? 0 : k + 1;
    end
  end

  // data model driven by the strobes seen in the previous half cycle
  always @(posedge Clock) begin
    if (cap_v[B_LDIVL] && !cap_v[B_DIVLP]) begin
      if (e_op) begin
        m_divl <= cap_v[B_IOP1] ? -tb_a : tb_a;
        m_opd  <= cap_v[B_IOP2] ? -tb_b : tb_b;
      end else begin
        m_divl <= cap_v[B_IOP2] ? -tb_b : tb_b;
        m_opd  <= cap_v[B_IOP1] ? -tb_a : tb_a;
      end
      m_divh <= '0; m_quot <= '0; m_rem <= '0;
    end else if (cap_v[B_DIVLP]) begin
      m_divh <= mul_sum[W:1];
      m_divl <= {mul_sum[0], m_divl[W-1:1]};
    end else if (cap_v[B_DIVHP]) begin
      m_divh <= cap_v[B_LACC] ? trial[W-1:0] : shifted[W-1:0];
      m_divl <= {m_divl[W-2:0], 1'b0};
      if (cap_v[B_LQUOT]) m_quot <= {m_quot[W-2:0], ~cap_v[B_IRES]};
    end else begin
      if (cap_v[B_LQUOT] && cap_v[B_IRES]) m_quot <= '1;
      if (cap_v[B_LREM]) m_rem <= cap_v[B_IREM] ? -m_divh : m_divh;
      if (cap_v[B_CIN] && cap_v[B_IRES]) begin
        if (cap_v[B_LREM]) m_quot <= -m_quot;
        else {m_divh, m_divl} <= prod_neg;
      end
    end
  end

  function automatic logic [13:0] expect_vec(input int kk, input logic op, input logic sg,
      input logic dz, input logic mb, input logic co, input logic s1, input logic s2);
    logic [13:0] v;
    logic sen;
    v = '0;
    sen = sg & SIGNED_EN;
    if (kk == 1) begin
      v[B_BUSY] = 1'b1;
      if (op && dz) begin
        v[B_LQUOT] = 1'b1; v[B_IRES] = 1'b1;
      end else begin
        v[B_LDIVL] = 1'b1; v[B_LDIVH] = 1'b1;
        if (sen) begin v[B_IOP1] = s1; v[B_IOP2] = s2; end
      end
    end else if (kk >= 2 && kk <= W + 1) begin
      v[B_BUSY] = 1'b1; v[B_DIVHP] = 1'b1;
      if (!op) begin
        v[B_LACC] = mb; v[B_DIVLP] = 1'b1;
      end else begin
        v[B_IOP2] = 1'b1; v[B_CIN] = 1'b1; v[B_LACC] = co;
        v[B_LQUOT] = 1'b1; v[B_IRES] = ~co;
      end
    end else if (kk == W + 2) begin
      v[B_BUSY] = 1'b1; v[B_LREM] = op;
      if (sen) begin v[B_IRES] = s1 ^ s2; v[B_IREM] = s1; v[B_CIN] = 1'b1; end
    end else if (kk == W + 3) begin
      v[B_DONE] = 1'b1;
    end
    return v;
  endfunction

  // per-cycle compare of every output against the schedule model
  always @(negedge Clock) begin
    cap_v <= dut_vec;
    if (armed)
      chk("cycle_outputs", {dut_vec, DivErr},
          {expect_vec(k, e_op, e_sgn, DivisorZero, MplrBit, ACC_Cout, Op1Sign, Op2Sign), e_err});
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input logic sg, output int done_cyc, output logic [W-1:0] acc_pat,
                        output int quot_cnt, output int busy_cnt, output int iter_cnt,
                        output logic lo_inv1, output logic fx_invres);
    done_cyc = -1; acc_pat = '0; quot_cnt = 0; busy_cnt = 0; iter_cnt = 0;
    lo_inv1 = 1'b0; fx_invres = 1'b0;
    @(posedge Clock); #1;
    tb_a = a; tb_b = b; Op = op; Signed = sg; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      if (Busy) busy_cnt++;
      if (LOAD_QUOT) quot_cnt++;
      if (Busy && DIVH_P) begin
        if (iter_cnt < W) acc_pat[iter_cnt] = LOAD_ACC;
        iter_cnt++;
      end
      if (c == 1) lo_inv1 = INV_OP1;
      if (c == W + 2) fx_invres = INV_RESULT;
      if (Done) begin done_cyc = c; break; end
    end
  endtask

  initial begin
    int dc, qc, bc, ic, dones, busies;
    logic [W-1:0] ap;
    logic li, fr;
    logic [W-1:0] ra, rb, eq, er;
    logic rop, rsg, use_s;
    logic [2*W-1:0] ep;
    int sa, sb;

    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("reset_outputs", {dut_vec, DivErr}, 32'd0);

    // 13 * 11
    run_op(8'd13, 8'd11, 1'b0, 1'b0, dc, ap, qc, bc, ic, li, fr);
    chk("mul_done_cycle", dc, 11);
    chk("mul_load_acc_pattern", ap, 8'b0000_1011);
    chk("mul_product", {m_divh, m_divl}, 16'd143);
    chk("mul_busy_cycles", bc, 10);

    // 100 / 7
    run_op(8'd100, 8'd7, 1'b1, 1'b0, dc, ap, qc, bc, ic, li, fr);
    chk("div_done_cycle", dc, 11);
    chk("div_quotient", m_quot, 8'd14);
    chk("div_remainder", m_rem, 8'd2);
    chk("div_load_quot_cycles", qc, 8);
    chk("div_err_clear", DivErr, 1'b0);

    // 55 / 0
    run_op(8'd55, 8'd0, 1'b1, 1'b0, dc, ap, qc, bc, ic, li, fr);
    chk("dz_done_cycle", dc, 2);
    chk("dz_div_err", DivErr, 1'b1);
    chk("dz_quotient", m_quot, 8'hFF);
    chk("dz_iter_cycles", ic, 0);

    // Start held high across two operations
    @(posedge Clock); #1;
    tb_a = 8'd9; tb_b = 8'd3; Op = 1'b0; Signed = 1'b0; Start = 1'b1;
    @(posedge Clock); #1;
    dones = 0; busies = 0; bc = 0;
    for (int c = 1; c <= 23; c++) begin
      @(negedge Clock);
      if (Done) dones++;
      if (Busy) busies++;
      if (Busy && c <= 11) bc++;
    end
    chk("held_first_busy", bc, 10);
    chk("held_done_pulses", dones, 2);
    chk("held_busy_total", busies, 20);
    @(posedge Clock); #1 Start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      chk("held_idle_after", Busy, 1'b0);
    end

    // Reset in the fourth ITER cycle
    @(posedge Clock); #1;
    tb_a = 8'd200; tb_b = 8'd3; Op = 1'b0; Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    chk("reset_mid_iter", {dut_vec, DivErr}, 32'd0);
    run_op(8'd200, 8'd3, 1'b0, 1'b0, dc, ap, qc, bc, ic, li, fr);
    chk("post_reset_done_cycle", dc, 11);
    chk("post_reset_product", {m_divh, m_divl}, 16'd600);

    // -6 * 5 with Signed
    run_op(8'hFA, 8'd5, 1'b0, 1'b1, dc, ap, qc, bc, ic, li, fr);
    chk("sgn_load_inv_op1", li, SIGNED_EN);
    chk("sgn_fixup_inv_result", fr, SIGNED_EN);
    chk("sgn_product", {m_divh, m_divl}, SIGNED_EN ? 16'hFFE2 : 16'h04E2);
    chk("sgn_done_cycle", dc, 11);

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rop = 1'($urandom);
      rsg = 1'($urandom);
      run_op(ra, rb, rop, rsg, dc, ap, qc, bc, ic, li, fr);
      use_s = SIGNED_EN & rsg;
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (!rop) begin
        ep = use_s ? (2*W)'(sa * sb) : (2*W)'(ra) * (2*W)'(rb);
        chk("rnd_mul_done", dc, W + 3);
        chk("rnd_mul_product", {m_divh, m_divl}, ep);
      end else if (rb == '0) begin
        chk("rnd_dz_done", dc, 2);
        chk("rnd_dz_err", DivErr, 1'b1);
        chk("rnd_dz_quot", m_quot, 8'hFF);
      end else begin
        eq = use_s ? W'(sa / sb) : ra / rb;
        er = use_s ? W'(sa % sb) : ra % rb;
        chk("rnd_div_done", dc, W + 3);
        chk("rnd_div_err", DivErr, 1'b0);
        chk("rnd_div_quot", m_quot, eq);
        chk("rnd_div_rem", m_rem, er);
      end
    end

    @(posedge Clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
